// File: rtl/msrv32_decode_queue.sv
// Two-entry decode queue between fetch and the immediate generator. Each entry stores
// instruction bits [31:7] with the immediate type and the illegal flag decoded when it is pushed.
module msrv32_decode_queue (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        flush_in,
  input  logic        instr_valid_in,
  input  logic [31:0] instr_in,
  output logic        instr_ready_out,
  output logic        dec_valid_out,
  input  logic        dec_ready_in,
  output logic [24:0] dec_instr_out,
  output logic [2:0]  imm_type_out,
  output logic        illegal_out,
  output logic [1:0]  count_out
);

  localparam int unsigned INSTR_W = 25;
  localparam int unsigned IMM_W   = 3;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [IMM_W-1:0]   imm_type;
    logic               illegal;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state;
  state_t next_state;
  entry_t head;
  entry_t tail;
  entry_t new_entry;
  logic   push;
  logic   pop;

  // Decode the incoming word so that only the result is stored with the entry.
  always_comb begin
    new_entry       = '0;
    new_entry.instr = instr_in[31:7];
    unique case (instr_in[6:0])
      7'b0000011:             new_entry.imm_type = IMM_W'(0);
      7'b0010011, 7'b1100111: new_entry.imm_type = IMM_W'(1);
      7'b0100011:             new_entry.imm_type = IMM_W'(2);
      7'b1100011:             new_entry.imm_type = IMM_W'(3);
      7'b0110111, 7'b0010111: new_entry.imm_type = IMM_W'(4);
      7'b1101111:             new_entry.imm_type = IMM_W'(5);
      7'b1110011:             new_entry.imm_type = instr_in[14] ? IMM_W'(6) : IMM_W'(0);
      7'b0110011, 7'b0001111: new_entry.imm_type = IMM_W'(0);
      default:                new_entry.illegal  = 1'b1;
    endcase
  end

  // Occupancy state register.
  always_ff @(posedge clk_in) begin
    if (rst_in) state <= EMPTY;
    else        state <= next_state;
  end

  // Handshakes use registered state only, so readiness never depends on dec_ready_in.
  always_comb begin
    push       = instr_valid_in && (state != FULL) && !flush_in;
    pop        = dec_ready_in && (state != EMPTY) && !flush_in;
    next_state = state;
    if (flush_in) begin
      next_state = EMPTY;
    end else begin
      unique case (state)
        EMPTY:   if (push) next_state = ONE;
        ONE:     if (push && !pop) next_state = FULL;
                 else if (pop && !push) next_state = EMPTY;
        FULL:    if (pop) next_state = ONE;
        default: next_state = EMPTY;
      endcase
    end
  end

  // Entry storage: head is always the oldest entry; the tail is only meaningful when FULL.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head <= '0;
      tail <= '0;
    end else if (!flush_in) begin
      unique case (state)
        EMPTY: if (push) head <= new_entry;
        ONE: begin
          if (push && pop) head <= new_entry;
          else if (push)   tail <= new_entry;
        end
        FULL:  if (pop) head <= tail;
        default: ;
      endcase
    end
  end

  // Outputs decoded from registered state; data is zeroed while the queue is empty.
  always_comb begin
    instr_ready_out = 1'b1;
    dec_valid_out   = 1'b0;
    dec_instr_out   = '0;
    imm_type_out    = '0;
    illegal_out     = 1'b0;
    count_out       = 2'd0;
    unique case (state)
      ONE, FULL: begin
        dec_valid_out   = 1'b1;
        instr_ready_out = (state != FULL);
        count_out       = (state == FULL) ? 2'd2 : 2'd1;
        dec_instr_out   = head.instr;
        imm_type_out    = head.imm_type;
        illegal_out     = head.illegal;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_msrv32_decode_queue.sv
// Testbench for msrv32_decode_queue: directed scenarios followed by random traffic,
// compared every cycle against a queue-based reference model.
module tb_msrv32_decode_queue;

  logic        clk_in = 1'b0;
  logic        rst_in, flush_in, instr_valid_in, dec_ready_in;
  logic [31:0] instr_in;
  logic        instr_ready_out, dec_valid_out, illegal_out;
  logic [24:0] dec_instr_out;
  logic [2:0]  imm_type_out;
  logic [1:0]  count_out;

  int errors = 0;
  int checks = 0;
  bit checking = 0;

  typedef struct {
    logic [24:0] instr;
    logic [2:0]  imm;
    logic        ill;
  } ent_t;

  ent_t q[$];

  msrv32_decode_queue dut (
    .clk_in(clk_in), .rst_in(rst_in), .flush_in(flush_in),
    .instr_valid_in(instr_valid_in), .instr_in(instr_in),
    .instr_ready_out(instr_ready_out), .dec_valid_out(dec_valid_out),
    .dec_ready_in(dec_ready_in), .dec_instr_out(dec_instr_out),
    .imm_type_out(imm_type_out), .illegal_out(illegal_out), .count_out(count_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic ent_t ref_dec(input logic [31:0] w);
    ent_t e;
    e.instr = w[31:7];
    e.imm   = 3'd0;
    e.ill   = 1'b0;
    case (w[6:0])
      7'h03:        e.imm = 3'd0;
      7'h13, 7'h67: e.imm = 3'd1;
      7'h23:        e.imm = 3'd2;
      7'h63:        e.imm = 3'd3;
      7'h37, 7'h17: e.imm = 3'd4;
      7'h6F:        e.imm = 3'd5;
      7'h73:        e.imm = w[14] ? 3'd6 : 3'd0;
      7'h33, 7'h0F: e.imm = 3'd0;
      default:      e.ill = 1'b1;
    endcase
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    int n = q.size();
    chk("count", 32'(count_out), 32'(n));
    chk("valid", 32'(dec_valid_out), 32'(n > 0));
    chk("ready", 32'(instr_ready_out), 32'(n < 2));
    chk("instr", 32'(dec_instr_out), (n > 0) ? 32'(q[0].instr) : 32'd0);
    chk("imm",   32'(imm_type_out), (n > 0) ? 32'(q[0].imm) : 32'd0);
    chk("ill",   32'(illegal_out), (n > 0) ? 32'(q[0].ill) : 32'd0);
  endtask

  // One clock: apply inputs, compare current outputs to the model, then advance both.
  task automatic cyc(input logic r, input logic f, input logic v,
                     input logic [31:0] w, input logic rd);
    bit do_pop, do_push;
    rst_in = r; flush_in = f; instr_valid_in = v; instr_in = w; dec_ready_in = rd;
    #1;
    if (checking) check_outputs();
    do_pop  = (q.size() > 0) && rd;
    do_push = v && (q.size() < 2);
    @(posedge clk_in);
    if (r || f) begin
      q.delete();
    end else begin
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(ref_dec(w));
    end
    #1;
  endtask

  function automatic logic [31:0] rand_word();
    logic [6:0] ops [12] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37,
                             7'h17, 7'h6F, 7'h73, 7'h33, 7'h0F, 7'h0B};
    logic [31:0] w = $urandom;
    if ($urandom_range(3) != 0) w[6:0] = ops[$urandom_range(11)];
    return w;
  endfunction

  initial begin
    cyc(1, 0, 0, 32'h0, 0);
    checking = 1;
    cyc(1, 0, 1, 32'h00500093, 1);
    chk("reset_count", 32'(count_out), 32'd0);
    chk("reset_ready", 32'(instr_ready_out), 32'd1);

    // ADDI, no consumer
    cyc(0, 0, 1, 32'h00500093, 0);
    chk("addi_valid", 32'(dec_valid_out), 32'd1);
    chk("addi_imm", 32'(imm_type_out), 32'd1);
    chk("addi_instr", 32'(dec_instr_out), 32'h00500093 >> 7);
    chk("addi_ill", 32'(illegal_out), 32'd0);
    chk("addi_count", 32'(count_out), 32'd1);
    cyc(0, 0, 0, 32'h0, 1);

    // SW then JAL fill the queue; a third word is refused
    cyc(0, 0, 1, 32'hFE112E23, 0);
    cyc(0, 0, 1, 32'h0000006F, 0);
    chk("full_count", 32'(count_out), 32'd2);
    chk("full_ready", 32'(instr_ready_out), 32'd0);
    cyc(0, 0, 1, 32'h00000013, 0);
    chk("full_hold_count", 32'(count_out), 32'd2);
    chk("pop1_imm", 32'(imm_type_out), 32'd2);
    cyc(0, 0, 0, 32'h0, 1);
    chk("pop2_imm", 32'(imm_type_out), 32'd5);

    // Push and pop together at count 1
    cyc(0, 0, 1, 32'h00000037, 1);
    chk("lui_count", 32'(count_out), 32'd1);
    chk("lui_imm", 32'(imm_type_out), 32'd4);
    cyc(0, 0, 0, 32'h0, 1);

    // Unknown opcode, then CSRRWI replaces it as head
    cyc(0, 0, 1, 32'h0000000B, 0);
    chk("unk_ill", 32'(illegal_out), 32'd1);
    chk("unk_imm", 32'(imm_type_out), 32'd0);
    cyc(0, 0, 1, 32'h3400D073, 1);
    chk("csr_imm", 32'(imm_type_out), 32'd6);
    chk("csr_ill", 32'(illegal_out), 32'd0);

    // Flush while full with a push offered
    cyc(0, 0, 1, 32'h00000063, 0);
    cyc(0, 1, 1, 32'h00000013, 1);
    chk("flush_count", 32'(count_out), 32'd0);
    chk("flush_valid", 32'(dec_valid_out), 32'd0);
    chk("flush_instr", 32'(dec_instr_out), 32'd0);
    chk("flush_ready", 32'(instr_ready_out), 32'd1);

    // Reset while full with a push offered; nothing may reappear afterwards
    cyc(0, 0, 1, 32'hFFFFF017, 0);
    cyc(0, 0, 1, 32'h12345067, 0);
    cyc(1, 0, 1, 32'h00000003, 1);
    chk("rst_count", 32'(count_out), 32'd0);
    chk("rst_valid", 32'(dec_valid_out), 32'd0);
    chk("rst_imm", 32'(imm_type_out), 32'd0);
    cyc(0, 0, 0, 32'h0, 0);
    chk("rst_after_count", 32'(count_out), 32'd0);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      cyc(($urandom_range(63) == 0), ($urandom_range(15) == 0),
          1'($urandom_range(1)), rand_word(), 1'($urandom_range(1)));
    end
    #1 check_outputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/msrv32_decode_queue.md
MSRV32_DECODE_QUEUE -- requirements
Module: msrv32_decode_queue

Interface
REQ-001 Parameter: none; depth fixed at 2 entries.
REQ-002 clk_in  input  1  single clock; all state updates on rising edge.
REQ-003 rst_in  input  1  reset, synchronous and active-high.
REQ-004 flush_in  input  1  discard all queued entries; active-high.
REQ-005 instr_valid_in  input  1  fetch offers instruction on instr_in.
REQ-006 instr_in  input  32  raw RV32I instruction word.
REQ-007 instr_ready_out  output  1  queue can accept this cycle.
REQ-008 dec_valid_out  output  1  head entry valid toward immediate generator / execute.
REQ-009 dec_ready_in  input  1  consumer accepts head this cycle.
REQ-010 dec_instr_out  output  25  head instruction bits [31:7], for the immediate generator instr_in port.
REQ-011 imm_type_out  output  3  head immediate-type select, for the immediate generator imm_type_in port.
REQ-012 illegal_out  output  1  head opcode not recognised.
REQ-013 count_out  output  2  current occupancy, 0..2.

Function
REQ-014 Push when instr_valid_in & instr_ready_out & !flush_in; pop when dec_valid_out & dec_ready_in & !flush_in.
REQ-015 instr_ready_out SHALL be 1 when count_out < 2, 0 when count_out = 2; it SHALL depend only on registered state, not on dec_ready_in.
REQ-016 dec_valid_out SHALL be 1 exactly when count_out > 0.
REQ-017 Decode at push time, stored with entry; opcode = instr_in[6:0]:
- 0000011 LOAD -> 000
- 0010011 OP-IMM, 1100111 JALR -> 001
- 0100011 STORE -> 010
- 1100011 BRANCH -> 011
- 0110111 LUI, 0010111 AUIPC -> 100
- 1101111 JAL -> 101
- 1110011 SYSTEM with funct3[2]=1 -> 110
- 1110011 with funct3[2]=0, 0110011 OP, 0001111 MISC-MEM -> 000
REQ-018 Any other opcode SHALL store imm_type 000 with illegal = 1; listed opcodes store illegal = 0.
REQ-019 Latency: an entry pushed at edge N SHALL appear on the outputs at earliest after edge N; no combinational bypass from instr_in to the dec_* outputs.
REQ-020 FIFO order SHALL be strict; the head is the oldest entry.
REQ-021 Push only: count +1, new entry goes behind any existing entry.
REQ-022 Pop only: count -1, second entry (if any) becomes head.
REQ-023 Push and pop in the same cycle at count 1: count stays 1, new entry becomes head.
REQ-024 Push and pop at count 0: impossible; no pop, push only.
REQ-025 At count 2, instr_valid_in SHALL be ignored; a pop the same cycle yields count 1 with no push.
REQ-026 flush_in SHALL set count to 0 at the next edge, overriding any push or pop that cycle.
REQ-027 When count_out = 0, dec_instr_out, imm_type_out and illegal_out SHALL be 0.
REQ-028 Head outputs SHALL remain stable while dec_valid_out = 1 and dec_ready_in = 0.
REQ-029 Occupancy state machine:
- EMPTY (count 0) -> ONE on push.
- ONE -> EMPTY on pop without push.
- ONE -> FULL on push without pop.
- ONE stays ONE on push with pop.
- FULL -> ONE on pop.
- Any state -> EMPTY on flush.

Reset
REQ-030 On rst_in = 1 at an edge: count_out = 0, dec_valid_out = 0, instr_ready_out = 1, data outputs = 0; rst_in overrides flush, push and pop.
REQ-031 Reset asserted mid-operation SHALL discard both entries; no entry SHALL reappear after release.

Verification
REQ-032 Reset, then push 0x00500093 (ADDI) with dec_ready_in = 0 -> next cycle: dec_valid_out = 1, imm_type_out = 001, dec_instr_out = 0x00500093 >> 7, illegal_out = 0, count_out = 1.
REQ-033 Push 0xFE112E23 (SW), then 0x0000006F (JAL) with dec_ready_in = 0:
- count_out = 2, instr_ready_out = 0.
- A third offered word is not accepted.
- Pops return 010, then 101.
REQ-034 Hold count_out = 1, then push 0x00000037 (LUI) and pop the same cycle -> count_out stays 1, head imm_type_out = 100.
REQ-035 Push 0x0000000B (unknown opcode) -> illegal_out = 1, imm_type_out = 000; push 0x3400D073 (CSRRWI) -> imm_type_out = 110, illegal_out = 0.
REQ-036 At count_out = 2, assert flush_in together with instr_valid_in = 1 -> next cycle: count_out = 0, dec_valid_out = 0, outputs 0, instr_ready_out = 1.
REQ-037 Assert rst_in while count_out = 2 and a push is offered -> next cycle all outputs are at reset values.
